alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the command FIFO depth; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream command valid.
REQ-006 The block SHALL have port in_ready  output  1  command FIFO can accept a command.
REQ-007 The block SHALL have ports in_a and in_b  input  WIDTH  command operands.
REQ-008 The block SHALL have port in_oper  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 POW, 101 MOD, 110 L_S, 111 R_S.
REQ-009 The block SHALL have ports alu_a and alu_b  output  WIDTH  operands driven to the downstream combinational ALU.
REQ-010 The block SHALL have port alu_oper  output  3  opcode driven to the ALU.
REQ-011 The block SHALL have port alu_y  input  WIDTH  combinational ALU result for the driven alu_a, alu_b and alu_oper.
REQ-012 The block SHALL have port out_valid  output  1  result register holds a result.
REQ-013 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 The block SHALL have ports out_y (output, WIDTH, result), out_oper (output, 3, opcode of the result) and out_err (output, 1, divide or modulo by zero).
REQ-015 The block SHALL have port count  output  clog2(DEPTH)+1  current number of FIFO entries.
REQ-016 The block SHALL have port err_cnt  output  8  saturating count of error results.

Function
REQ-017 A command SHALL be pushed on any rising edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL equal (count != DEPTH); a push while full SHALL NOT be possible, even if a pop occurs in the same cycle.
REQ-019 alu_a, alu_b and alu_oper SHALL be driven combinationally from the FIFO head when count > 0, and SHALL be all-zero when count == 0.
REQ-020 The output register SHALL be able to load when out_valid == 0, or when out_valid == 1 and out_ready == 1.
REQ-021 The issue condition SHALL be count > 0 and the output register able to load.
REQ-022 On an issue edge, the head SHALL be popped and the output register loaded with out_y = alu_y, out_oper = head opcode and out_valid = 1.
REQ-023 A command with opcode 011 or 101 and b == 0 SHALL load out_y = 0 and out_err = 1, ignoring alu_y; every other command SHALL load out_err = 0.
REQ-024 When out_valid == 1 and out_ready == 1 and there is no issue, out_valid SHALL clear on that edge; out_y, out_oper and out_err SHALL hold their values.
REQ-025 When out_valid == 1 and out_ready == 0, out_y, out_oper, out_err and out_valid SHALL hold, and the FIFO SHALL NOT pop.
REQ-026 A push and an issue on the same edge SHALL leave count unchanged; the read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Latency SHALL be one cycle: a command pushed at edge N into an empty FIFO, with the output register free, SHALL give out_valid = 1 after edge N+1.
REQ-028 Throughput SHALL be one result per cycle while out_ready is held at 1 and the FIFO is non-empty.
REQ-029 Results SHALL leave the block in command order.
REQ-030 err_cnt SHALL increment on each issue edge that loads out_err = 1, and SHALL saturate at 255.
REQ-031 The output register SHALL act as a two-state machine: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-032 The EMPTY state SHALL go to FULL on issue.
REQ-033 The FULL state SHALL stay FULL when an issue coincides with out_ready = 1, and SHALL go to EMPTY when out_ready = 1 with no issue.

Reset
REQ-034 While rst_n = 0, the block SHALL asynchronously force count = 0, pointers = 0, out_valid = 0, out_y = 0, out_oper = 0, out_err = 0 and err_cnt = 0.
REQ-035 During reset, in_ready SHALL be 1 and alu_a, alu_b and alu_oper SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard all queued commands and any held result, with no output handshake.
REQ-037 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single ADD: push a = 5, b = 7, oper = 000 with out_ready = 1 -> one cycle later out_valid = 1, out_y = 12, out_err = 0.
REQ-039 Backpressure fill: hold out_ready = 0 and push 6 commands -> 1 result held, count = 4, in_ready = 0; then set out_ready = 1 -> 5 results drain in push order, one per cycle.
REQ-040 Divide by zero: push DIV a = 9, b = 0, then MOD a = 9, b = 4 -> first result out_y = 0, out_err = 1; second out_y = 1, out_err = 0; err_cnt = 1.
REQ-041 Streaming: push 8 mixed opcodes back-to-back with out_ready = 1 -> 8 results, one per cycle, with correct values (for example SUB 3 - 5 = 0xFFFFFFFE, L_S 3 = 12), and count never exceeds 1.
REQ-042 Reset mid-operation: with count = 3 and out_valid = 1, pulse rst_n low asynchronously between edges -> count = 0, out_valid = 0 and err_cnt = 0 immediately; no stale result appears afterward.
REQ-043 Saturation: issue 260 divide-by-zero commands -> err_cnt = 255.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: a command FIFO feeding an external combinational ALU, with a
// single output result register. A result is issued from the FIFO head whenever
// the output register is free or being drained in the same cycle. DIV/MOD by
// zero is trapped locally: the result is forced to zero, flagged, and counted.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_oper,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_oper,
  input  logic [WIDTH-1:0]         alu_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [2:0]               out_oper,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [2:0]    OP_DIV   = 3'b011;
  localparam logic [2:0]    OP_MOD   = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  // True when the command would divide (or take modulo) by zero.
  function automatic logic is_div_zero(input logic [2:0] op, input logic [WIDTH-1:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] mem_a_r  [DEPTH];
  logic [WIDTH-1:0] mem_b_r  [DEPTH];
  logic [2:0]       mem_op_r [DEPTH];

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;

  ostate_t          state_r;
  ostate_t          state_nxt_s;

  logic [WIDTH-1:0] out_y_r;
  logic [2:0]       out_oper_r;
  logic             out_err_r;
  logic [7:0]       err_cnt_r;

  logic             not_empty_s;
  logic             push_s;
  logic             can_load_s;
  logic             issue_s;
  logic             head_err_s;

  assign not_empty_s = (count_r != {CW{1'b0}});
  assign in_ready    = (count_r != FULL_CNT);
  assign push_s      = in_valid & in_ready;
  assign can_load_s  = (state_r == ST_EMPTY) | out_ready;
  assign issue_s     = not_empty_s & can_load_s;

  // Present the FIFO head to the ALU; zero when nothing is queued.
  always_comb begin
    alu_a    = {WIDTH{1'b0}};
    alu_b    = {WIDTH{1'b0}};
    alu_oper = 3'b000;
    if (not_empty_s) begin
      alu_a    = mem_a_r[rd_ptr_r];
      alu_b    = mem_b_r[rd_ptr_r];
      alu_oper = mem_op_r[rd_ptr_r];
    end else begin
      alu_a    = {WIDTH{1'b0}};
      alu_b    = {WIDTH{1'b0}};
      alu_oper = 3'b000;
    end
  end

  assign head_err_s = is_div_zero(alu_oper, alu_b);

  // FIFO storage write; contents are don't-care until the pointers reach them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_r[wr_ptr_r]  <= in_a;
      mem_b_r[wr_ptr_r]  <= in_b;
      mem_op_r[wr_ptr_r] <= in_oper;
    end
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, issue_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      count_r <= count_nxt_s;
    end
  end

  // Output register occupancy: refill on issue, drain when consumed without refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (issue_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (issue_s) begin
          state_nxt_s = ST_FULL;
        end else if (out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result payload; loaded only on issue, otherwise held even after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y_r    <= {WIDTH{1'b0}};
      out_oper_r <= 3'b000;
      out_err_r  <= 1'b0;
    end else if (issue_s) begin
      out_y_r    <= head_err_s ? {WIDTH{1'b0}} : alu_y;
      out_oper_r <= alu_oper;
      out_err_r  <= head_err_s;
    end
  end

  // Saturating count of error results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (issue_s && head_err_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign out_valid = (state_r == ST_FULL);
  assign out_y     = out_y_r;
  assign out_oper  = out_oper_r;
  assign out_err   = out_err_r;
  assign count     = count_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. The bench supplies the combinational
// ALU, predicts every result into a scoreboard queue when a command is pushed,
// and a monitor pops and compares each result as it is handed off.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] y;
    logic [2:0]  op;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_oper;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_oper;
  logic [31:0] alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [2:0]  out_oper;
  logic        out_err;
  logic [2:0]  count;
  logic [7:0]  err_cnt;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   pop_cnt = 0;
  int   max_count = 0;
  exp_t sb[$];

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_oper(in_oper),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_oper(out_oper), .out_err(out_err),
    .count(count), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; division by zero returns junk that the DUT must discard.
  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
      3'd4: begin
        r = 32'd1;
        for (int i = 0; i < 32; i++) if (i < b) r = r * a;
      end
      3'd5: r = (b == 32'd0) ? 32'hBAAD_F00D : a % b;
      3'd6: r = a << b;
      3'd7: r = a >> b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_y = alu_model(alu_oper, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one command, wait (bounded) for acceptance, record its expected result.
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_oper  = op;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", {63'd0, in_ready}, 64'd1);
    e.err = ((op == 3'd3) || (op == 3'd5)) && (b == 32'd0);
    e.y   = e.err ? 32'd0 : alu_model(op, a, b);
    e.op  = op;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  // Monitor: a result is handed off on the next edge when valid and ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (int'(count) > max_count) max_count = int'(count);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", {63'd0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("res_y", {32'd0, out_y}, {32'd0, e.y});
            check("res_oper", {61'd0, out_oper}, {61'd0, e.op});
            check("res_err", {63'd0, out_err}, {63'd0, e.err});
          end
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    int p0;
    rst_n = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_oper = 3'd0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("rst_alu_oper", {61'd0, alu_oper}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("rst_out_y", {32'd0, out_y}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Single ADD, first push on the first edge after reset release.
    push(3'd0, 32'd5, 32'd7);
    in_valid = 1'b0;
    check("add_count_after_push", {61'd0, count}, 64'd1);
    check("add_not_yet_valid", {63'd0, out_valid}, 64'd0);
    check("add_alu_a", {32'd0, alu_a}, 64'd5);
    @(posedge clk); #1;
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_y", {32'd0, out_y}, 64'd12);
    check("add_err", {63'd0, out_err}, 64'd0);
    @(posedge clk); #1;
    check("add_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: five accepted, sixth refused while full.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i), 32'(40 + i), 32'(i + 1));
    check("bp_count_full", {61'd0, count}, 64'd4);
    in_valid = 1'b1; in_a = 32'd99; in_b = 32'd1; in_oper = 3'd0;
    #1;
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_count_hold", {61'd0, count}, 64'd4);
    check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
    check("bp_y_hold", {32'd0, out_y}, {32'd0, sb[0].y});
    out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      @(posedge clk); #1;
      check("bp_drain_count", {61'd0, count}, 64'(k));
    end
    @(posedge clk); #1;
    check("bp_done_valid", {63'd0, out_valid}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Divide by zero followed by a normal MOD.
    push(3'd3, 32'd9, 32'd0);
    push(3'd5, 32'd9, 32'd4);
    in_valid = 1'b0;
    wait_drain();
    check("dz_err_cnt", {56'd0, err_cnt}, 64'd1);

    // Streaming eight mixed opcodes back-to-back.
    max_count = 0;
    p0 = pop_cnt;
    push(3'd0, 32'd10, 32'd20);
    push(3'd1, 32'd3, 32'd5);
    push(3'd2, 32'd6, 32'd7);
    push(3'd3, 32'd100, 32'd7);
    push(3'd4, 32'd2, 32'd10);
    push(3'd5, 32'd100, 32'd7);
    push(3'd6, 32'd3, 32'd2);
    push(3'd7, 32'h80, 32'd3);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_results", 64'(pop_cnt - p0), 64'd8);
    check("stream_max_count", 64'(max_count), 64'd1);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with queued commands and a held result.
    out_ready = 1'b0;
    push(3'd3, 32'd5, 32'd0);
    push(3'd0, 32'd1, 32'd1);
    push(3'd0, 32'd2, 32'd2);
    push(3'd0, 32'd3, 32'd3);
    in_valid = 1'b0;
    check("mid_count", {61'd0, count}, 64'd3);
    check("mid_valid", {63'd0, out_valid}, 64'd1);
    check("mid_err_cnt", {56'd0, err_cnt}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", {61'd0, count}, 64'd0);
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("mid_rst_alu_b", {32'd0, alu_b}, 64'd0);
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_count", {61'd0, count}, 64'd0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) push(3'(3 + 2 * (i % 2)), 32'(i), 32'd0);
    in_valid = 1'b0;
    wait_drain();
    check("sat_err_cnt", {56'd0, err_cnt}, 64'd255);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
